// File: rtl/uart_tx_sequencer_if.sv
// Byte-stream input and UART register-bus signals of uart_tx_sequencer.
// The sequencer uses the master modport; the upstream source and UART side use slave.
interface uart_tx_sequencer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          busy;
    logic [LW-1:0] level;
    logic          uart_cs;
    logic          uart_rd;
    logic          uart_wr;
    logic [2:0]    uart_addr;
    logic [7:0]    uart_wdata;
    logic [7:0]    uart_rdata;

    modport master (
        input  in_valid, in_byte, uart_rdata,
        output in_ready, busy, level,
        output uart_cs, uart_rd, uart_wr, uart_addr, uart_wdata
    );

    modport slave (
        output in_valid, in_byte, uart_rdata,
        input  in_ready, busy, level,
        input  uart_cs, uart_rd, uart_wr, uart_addr, uart_wdata
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Buffers a byte stream and feeds the UART Tx register: poll control reg (addr 0) until idle, then write addr 2.
// Defining UART_TX_CRLF_EN inserts a 0x0D write ahead of every 0x0A byte.
module uart_tx_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BUSY_BIT = 1,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic                clock,
    input  logic                reset,
    uart_tx_sequencer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam logic [2:0]  BB = 3'(BUSY_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_SETUP,
        S_POLL_READ,
        S_POLL_SAMPLE,
        S_POLL_WAIT,
        S_WRITE_SETUP,
        S_WRITE_STROBE,
        S_WRITE_DONE
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    state_t        r_state;
    logic          r_cs;
    logic          r_rd;
    logic          r_wr;
    logic [2:0]    r_addr;
    logic [7:0]    r_wdata;
    logic [GW-1:0] r_gap;
    logic          r_tx_busy;

    logic          w_in_ready;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_start_write;
    logic [7:0]    w_head;
    logic [7:0]    w_tx_byte;

    assign w_in_ready    = (r_level != LW'(DEPTH));
    assign w_empty       = (r_level == '0);
    assign w_push        = bus.in_valid & w_in_ready;
    assign w_head        = r_mem[r_rptr];
    assign w_start_write = (r_state == S_POLL_SAMPLE) && !r_tx_busy;

`ifdef UART_TX_CRLF_EN
    logic r_cr_sent;
    logic w_insert_cr;

    // A 0x0A head is written twice: first as 0x0D (kept in FIFO), then as itself (popped).
    assign w_insert_cr = (w_head == 8'h0A) && !r_cr_sent;
    assign w_tx_byte   = w_insert_cr ? 8'h0D : w_head;
    assign w_pop       = w_start_write & ~w_insert_cr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cr_sent <= 1'b0;
        end else if (w_start_write) begin
            r_cr_sent <= w_insert_cr;
        end
    end
`else
    assign w_tx_byte = w_head;
    assign w_pop     = w_start_write;
`endif

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.in_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Outputs are loaded on the edge entering each state; cs stays low through the
    // sample/done cycles so it brackets every strobe by one cycle on each side.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cs      <= 1'b1;
            r_rd      <= 1'b1;
            r_wr      <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_gap     <= '0;
            r_tx_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_POLL_SETUP;
                        r_cs    <= 1'b0;
                        r_addr  <= 3'd0;
                    end
                end
                S_POLL_SETUP: begin
                    r_state <= S_POLL_READ;
                    r_rd    <= 1'b0;
                end
                S_POLL_READ: begin
                    r_state   <= S_POLL_SAMPLE;
                    r_rd      <= 1'b1;
                    r_tx_busy <= bus.uart_rdata[BB];
                end
                S_POLL_SAMPLE: begin
                    if (r_tx_busy) begin
                        r_state <= S_POLL_WAIT;
                        r_cs    <= 1'b1;
                        r_gap   <= GW'(POLL_GAP);
                    end else begin
                        r_state <= S_WRITE_SETUP;
                        r_addr  <= 3'd2;
                        r_wdata <= w_tx_byte;
                    end
                end
                S_POLL_WAIT: begin
                    r_gap <= r_gap - GW'(1);
                    if (r_gap == GW'(1)) begin
                        r_state <= S_POLL_SETUP;
                        r_cs    <= 1'b0;
                        r_addr  <= 3'd0;
                    end
                end
                S_WRITE_SETUP: begin
                    r_state <= S_WRITE_STROBE;
                    r_wr    <= 1'b0;
                end
                S_WRITE_STROBE: begin
                    r_state <= S_WRITE_DONE;
                    r_wr    <= 1'b1;
                end
                S_WRITE_DONE: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                    r_rd    <= 1'b1;
                    r_wr    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.level      = r_level;
    assign bus.busy       = !w_empty || (r_state != S_IDLE);
    assign bus.uart_cs    = r_cs;
    assign bus.uart_rd    = r_rd;
    assign bus.uart_wr    = r_wr;
    assign bus.uart_addr  = r_addr;
    assign bus.uart_wdata = r_wdata;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed self-checking bench for uart_tx_sequencer (DEPTH=8, BUSY_BIT=1, POLL_GAP=4).
// Expected CRLF behaviour follows UART_TX_CRLF_EN when the bench is built with it.
module tb_uart_tx_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_tx_sequencer_if #(.DEPTH(8)) bus ();

    uart_tx_sequencer #(
        .DEPTH   (8),
        .BUSY_BIT(1),
        .POLL_GAP(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [10:0] wq[$];
    int          gap_q[$];
    int          rd_starts = 0;
    int          viol = 0;
    int          cs_run = 0;
    logic        p_valid = 1'b0;
    logic        p_cs, p_rd, p_wr;
    logic [2:0]  p_addr;
    logic [7:0]  p_wdata;

    // Bus observer: records write cycles, read-strobe spacing and protocol violations.
    always @(negedge clock) begin : monitor
        bit s_now, s_prev, bad;
        if (!reset) begin
            p_valid <= 1'b0;
        end else begin
            s_now = !bus.uart_rd || !bus.uart_wr;
            if (!bus.uart_wr) wq.push_back({bus.uart_addr, bus.uart_wdata});
            if (p_valid) begin
                s_prev = !p_rd || !p_wr;
                bad = (!bus.uart_rd && !bus.uart_wr) || (s_now && bus.uart_cs) ||
                      (!bus.uart_wr && !p_wr) || (s_now && !s_prev && p_cs) ||
                      (s_prev && !s_now && bus.uart_cs) ||
                      ((s_now || s_prev) && (bus.uart_addr != p_addr || bus.uart_wdata != p_wdata));
                if (bad) viol <= viol + 1;
            end
            if (!bus.uart_rd && (!p_valid || p_rd)) begin
                rd_starts <= rd_starts + 1;
                gap_q.push_back(cs_run);
                cs_run <= 0;
            end else if (bus.uart_cs) begin
                cs_run <= cs_run + 1;
            end
            p_cs    <= bus.uart_cs;
            p_rd    <= bus.uart_rd;
            p_wr    <= bus.uart_wr;
            p_addr  <= bus.uart_addr;
            p_wdata <= bus.uart_wdata;
            p_valid <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_w(input int idx);
        if (idx < wq.size()) return 32'(wq[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    // Called at a negedge; leaves in_valid high so bytes can go back-to-back.
    task automatic push(input logic [7:0] b);
        int t;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (t = 0; !bus.in_ready && t < 400; t++) @(negedge clock);
        check("push_ready_timeout", 32'(t < 400), 32'd1);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; bus.busy && t < 2000; t++) @(negedge clock);
        check("idle_timeout", 32'(t < 2000), 32'd1);
    endtask

    task automatic wait_writes(input int base, input int n, output int drops);
        int t;
        drops = 0;
        for (t = 0; (wq.size() - base) < n && t < 3000; t++) begin
            @(negedge clock);
            if ((wq.size() - base) >= 1 && (wq.size() - base) < n && !bus.busy) drops++;
        end
        check("write_timeout", 32'(t < 3000), 32'd1);
    endtask

    initial begin : stim
        int wb, rb, gb, k, drops, n;
        logic [7:0] exp_bytes[$];

        bus.in_valid   = 1'b1;
        bus.in_byte    = 8'h55;
        bus.uart_rdata = 8'h00;

        // Reset held with in_valid asserted
        repeat (3) @(negedge clock);
        check("rst_cs", bus.uart_cs, 1);
        check("rst_rd", bus.uart_rd, 1);
        check("rst_wr", bus.uart_wr, 1);
        check("rst_addr", bus.uart_addr, 0);
        check("rst_wdata", bus.uart_wdata, 0);
        check("rst_level", bus.level, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        reset = 1'b1;
        @(negedge clock);
        check("first_push_level", bus.level, 1);
        bus.in_valid = 1'b0;
        wb = wq.size();
        wait_writes(wb, 1, drops);
        check("first_push_write", get_w(wb), 32'h255);
        wait_idle();

        // Single byte, UART idle: latency and pulse shape
        repeat (2) @(negedge clock);
        wb = wq.size();
        push(8'h4F);
        bus.in_valid = 1'b0;
        k = 1;
        while (bus.uart_wr && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("single_latency", k, 6);
        check("single_addr", bus.uart_addr, 2);
        check("single_wdata", bus.uart_wdata, 8'h4F);
        check("single_cs", bus.uart_cs, 0);
        @(negedge clock);
        check("single_wr_1cyc", bus.uart_wr, 1);
        check("single_busy_done", bus.busy, 1);
        @(negedge clock);
        check("single_busy_idle", bus.busy, 0);
        check("single_cs_idle", bus.uart_cs, 1);
        repeat (10) @(negedge clock);
        check("single_count", wq.size() - wb, 1);

        // Busy polling: three busy polls, then free
        rb = rd_starts;
        gb = gap_q.size();
        wb = wq.size();
        bus.uart_rdata = 8'h02;
        push(8'h5A);
        push(8'hA5);
        bus.in_valid = 1'b0;
        for (k = 0; (rd_starts - rb) < 3 && k < 300; k++) @(negedge clock);
        check("poll_timeout", 32'(k < 300), 32'd1);
        @(negedge clock);
        bus.uart_rdata = 8'h00;
        wait_writes(wb, 2, drops);
        wait_idle();
        check("poll_rd_count", rd_starts - rb, 5);
        for (int i = 1; i <= 3; i++)
            check("poll_gap", (gb + i < gap_q.size()) ? gap_q[gb + i] : -1, 4);
        check("poll_w0", get_w(wb), 32'h25A);
        check("poll_w1", get_w(wb + 1), 32'h2A5);
        check("poll_busy_drop", drops, 0);

        // FIFO full and pointer wrap
        wb = wq.size();
        bus.uart_rdata = 8'h02;
        for (int i = 0; i < 8; i++) push(8'(i));
        bus.in_byte = 8'h08;
        check("full_level", bus.level, 8);
        check("full_in_ready", bus.in_ready, 0);
        repeat (3) @(negedge clock);
        check("full_level_hold", bus.level, 8);
        check("full_busy", bus.busy, 1);
        check("full_no_write", wq.size() - wb, 0);
        bus.uart_rdata = 8'h00;
        for (int i = 8; i < 12; i++) push(8'(i));
        bus.in_valid = 1'b0;
        wait_writes(wb, 12, drops);
        wait_idle();
        for (int i = 0; i < 12; i++) check("wrap_order", get_w(wb + i), 32'h200 | 32'(i));

        // Reset asserted during the write strobe
        push(8'h11);
        push(8'h22);
        bus.in_valid = 1'b0;
        for (k = 0; bus.uart_wr && k < 100; k++) @(negedge clock);
        check("rstmid_timeout", 32'(k < 100), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_wr", bus.uart_wr, 1);
        check("rstmid_cs", bus.uart_cs, 1);
        check("rstmid_rd", bus.uart_rd, 1);
        check("rstmid_level", bus.level, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_wdata", bus.uart_wdata, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wb = wq.size();
        rb = rd_starts;
        repeat (20) @(negedge clock);
        check("rstmid_no_write", wq.size() - wb, 0);
        check("rstmid_no_poll", rd_starts - rb, 0);
        check("rstmid_level_after", bus.level, 0);

        // CR insertion ahead of LF
        wb = wq.size();
`ifdef UART_TX_CRLF_EN
        exp_bytes = '{8'h41, 8'h0D, 8'h0A};
`else
        exp_bytes = '{8'h41, 8'h0A};
`endif
        n = exp_bytes.size();
        push(8'h41);
        push(8'h0A);
        bus.in_valid = 1'b0;
        wait_writes(wb, n, drops);
        repeat (30) @(negedge clock);
        check("crlf_count", wq.size() - wb, n);
        for (int i = 0; i < n; i++) check("crlf_byte", get_w(wb + i), 32'h200 | 32'(exp_bytes[i]));
        check("crlf_busy_drop", drops, 0);
        check("crlf_busy_end", bus.busy, 0);

        check("bus_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
